// File: rtl/inst_encoder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inst_encoder_pkg
// Description : Shared definitions for the RV32 instruction encoder.
//               - ALU_* operation codes and their RV32 funct3/funct7 values
//               - enc_op_t request classes
//               - enc_state_t encoder FSM states
//               - RV32 major opcodes
//               - field-packing and immediate range-check helpers
// Revision    : 1.0 - initial release
// ============================================================================
package inst_encoder_pkg;

    // ALU operation codes carried on req_func for the R and I_ARITH classes.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    // funct3 / funct7 values.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    // RV32 major opcodes.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Request classes; codes 11..15 are illegal.
    typedef enum logic [3:0] {
        OP_R       = 4'd0,
        OP_I_ARITH = 4'd1,
        OP_LD      = 4'd2,
        OP_ST      = 4'd3,
        OP_BR      = 4'd4,
        OP_JAL     = 4'd5,
        OP_JALR    = 4'd6,
        OP_LUI     = 4'd7,
        OP_AUIPC   = 4'd8,
        OP_EBREAK  = 4'd9,
        OP_LI      = 4'd10
    } enc_op_t;

    // ST_LI2: LUI of a two-word LI is in (or heading for) the slot, ADDI pending.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LI2  = 1'b1
    } enc_state_t;

    // True when v, read as signed, fits in a signed field of 'bits' bits:
    // everything from the field's sign bit upward must be a sign copy.
    function automatic logic f_fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] w_hi;
        w_hi = $signed(v) >>> (bits - 1);
        return (w_hi == '0) || (w_hi == '1);
    endfunction

    // I-type packing.
    function automatic logic [31:0] f_enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                            input logic [2:0] f3, input logic [4:0] rd,
                                            input logic [6:0] opc);
        return {imm12, rs1, f3, rd, opc};
    endfunction

endpackage : inst_encoder_pkg
`default_nettype wire

// File: rtl/inst_encoder_enc_fields.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : enc_fields
// Description : Combinational field mapper. Turns one encode request into a
//               single RV32 word plus a legality flag. For a two-word LI it
//               produces the LUI half; the trailing ADDI is built by the
//               parent from the registered rd/low-immediate.
// Ports       : op_i    - request class (enc_op_t)
//               func_i  - ALU_* code, or funct3 in [2:0] for LD/ST/BR
//               rd_i, rs1_i, rs2_i - register indices
//               imm_i   - signed immediate / full constant
//               inst_o  - encoded instruction (don't care when !legal_o)
//               legal_o - class, function and immediate are all acceptable
// Config      : ENC_MEXT_EN - when defined, R-class MUL..REMU are legal
// Revision    : 1.0 - initial release
// ============================================================================
module enc_fields
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  func_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] inst_o,
    output logic        legal_o
);

`ifdef ENC_MEXT_EN
    localparam logic C_MEXT_EN = 1'b1;
`else
    localparam logic C_MEXT_EN = 1'b0;
`endif

    enc_op_t     w_op;
    logic [2:0]  w_alu_f3;
    logic        w_alu_alt;     // SUB / SRA: selects inst[30]
    logic        w_alu_shift;   // SLL / SRL / SRA: immediate form uses shamt
    logic        w_alu_base;    // RV32I code
    logic        w_alu_mext;    // M-extension code
    logic [6:0]  w_r_f7;
    logic [11:0] w_i_imm;
    logic [19:0] w_li_hi;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;

    assign w_op     = enc_op_t'(op_i);
    assign w_fits12 = f_fits_signed(imm_i, 12);
    assign w_fits13 = f_fits_signed(imm_i, 13);
    assign w_fits21 = f_fits_signed(imm_i, 21);

    // (imm + 0x800)[31:12] without a 32-bit adder: the +0x800 only carries
    // into bit 12 when bit 11 is set.
    assign w_li_hi  = imm_i[31:12] + {19'd0, imm_i[11]};

    always_comb begin
        w_alu_f3    = F3_ADD_SUB;
        w_alu_alt   = 1'b0;
        w_alu_shift = 1'b0;
        w_alu_base  = 1'b1;
        w_alu_mext  = 1'b0;
        case (func_i)
            ALU_ADD:    w_alu_f3 = F3_ADD_SUB;
            ALU_SUB:    begin w_alu_f3 = F3_ADD_SUB; w_alu_alt = 1'b1; end
            ALU_SLL:    begin w_alu_f3 = F3_SLL;     w_alu_shift = 1'b1; end
            ALU_SLT:    w_alu_f3 = F3_SLT;
            ALU_SLTU:   w_alu_f3 = F3_SLTU;
            ALU_XOR:    w_alu_f3 = F3_XOR;
            ALU_SRL:    begin w_alu_f3 = F3_SRL_SRA; w_alu_shift = 1'b1; end
            ALU_SRA:    begin w_alu_f3 = F3_SRL_SRA; w_alu_shift = 1'b1; w_alu_alt = 1'b1; end
            ALU_OR:     w_alu_f3 = F3_OR;
            ALU_AND:    w_alu_f3 = F3_AND;
            ALU_MUL:    begin w_alu_f3 = 3'd0; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_MULH:   begin w_alu_f3 = 3'd1; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_MULHSU: begin w_alu_f3 = 3'd2; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_MULHU:  begin w_alu_f3 = 3'd3; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_DIV:    begin w_alu_f3 = 3'd4; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_DIVU:   begin w_alu_f3 = 3'd5; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_REM:    begin w_alu_f3 = 3'd6; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            ALU_REMU:   begin w_alu_f3 = 3'd7; w_alu_base = 1'b0; w_alu_mext = 1'b1; end
            default:    w_alu_base = 1'b0;
        endcase
    end

    assign w_r_f7  = w_alu_mext ? F7_MEXT : (w_alu_alt ? F7_ALT : F7_BASE);
    // Immediate shifts: only shamt plus the SRA select bit, upper imm ignored.
    assign w_i_imm = w_alu_shift ? {1'b0, w_alu_alt, 5'b00000, imm_i[4:0]} : imm_i[11:0];

    always_comb begin
        inst_o  = '0;
        legal_o = 1'b0;
        case (w_op)
            OP_R: begin
                legal_o = w_alu_base || (C_MEXT_EN && w_alu_mext);
                inst_o  = {w_r_f7, rs2_i, rs1_i, w_alu_f3, rd_i, OPC_OP};
            end
            OP_I_ARITH: begin
                legal_o = w_alu_base && (func_i != ALU_SUB) && (w_alu_shift || w_fits12);
                inst_o  = f_enc_i(w_i_imm, rs1_i, w_alu_f3, rd_i, OPC_OP_IMM);
            end
            OP_LD: begin
                legal_o = w_fits12;
                inst_o  = f_enc_i(imm_i[11:0], rs1_i, func_i[2:0], rd_i, OPC_LOAD);
            end
            OP_ST: begin
                legal_o = w_fits12;
                inst_o  = {imm_i[11:5], rs2_i, rs1_i, func_i[2:0], imm_i[4:0], OPC_STORE};
            end
            OP_BR: begin
                legal_o = w_fits13 && !imm_i[0];
                inst_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func_i[2:0],
                           imm_i[4:1], imm_i[11], OPC_BRANCH};
            end
            OP_JAL: begin
                legal_o = w_fits21 && !imm_i[0];
                inst_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            end
            OP_JALR: begin
                legal_o = w_fits12;
                inst_o  = f_enc_i(imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR);
            end
            OP_LUI: begin
                legal_o = 1'b1;
                inst_o  = {imm_i[31:12], rd_i, OPC_LUI};
            end
            OP_AUIPC: begin
                legal_o = 1'b1;
                inst_o  = {imm_i[31:12], rd_i, OPC_AUIPC};
            end
            OP_EBREAK: begin
                legal_o = 1'b1;
                inst_o  = INST_EBREAK;
            end
            OP_LI: begin
                legal_o = 1'b1;
                if (w_fits12) begin
                    inst_o = f_enc_i(imm_i[11:0], 5'd0, F3_ADD_SUB, rd_i, OPC_OP_IMM);
                end else begin
                    inst_o = {w_li_hi, rd_i, OPC_LUI};
                end
            end
            default: begin
                legal_o = 1'b0;
                inst_o  = '0;
            end
        endcase
    end

endmodule : enc_fields
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inst_encoder
// Description : RV32 instruction encoder with a single registered output
//               slot. Accepts one request per handshake, emits its encoding
//               one cycle later, and expands large-constant LI into LUI+ADDI.
//               Illegal requests are consumed silently and raise sticky err.
// Parameters  : BASE_PC - address tagged on the first emitted instruction
// Ports       : clk, rst (sync, active-high)
//               req_vld/req_rdy, req_op, req_func, req_rd/rs1/rs2, req_imm
//               out_vld/out_rdy, out_inst, out_pc
//               err     - sticky illegal-request flag
// Config      : ENC_MEXT_EN - enables R-class M-extension encodings
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_func,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        err
);

    enc_state_t  r_state_q;
    logic        r_out_vld_q;
    logic [31:0] r_out_inst_q;
    logic [31:0] r_out_pc_q;
    logic [31:0] w_out_pc_d;
    logic        r_err_q;
    logic [4:0]  r_li_rd_q;
    logic [11:0] r_li_lo_q;

    logic [31:0] w_enc_inst;
    logic        w_enc_legal;
    logic        w_slot_free;
    logic        w_drain;
    logic        w_accept;
    logic        w_li_two;
    logic        w_load_first;
    logic        w_load_addi;
    logic [31:0] w_addi_inst;

    enc_fields u_enc_fields (
        .op_i    (req_op),
        .func_i  (req_func),
        .rd_i    (req_rd),
        .rs1_i   (req_rs1),
        .rs2_i   (req_rs2),
        .imm_i   (req_imm),
        .inst_o  (w_enc_inst),
        .legal_o (w_enc_legal)
    );

    // Slot can take a new word when empty or being drained this cycle.
    assign w_drain      = r_out_vld_q && out_rdy;
    assign w_slot_free  = !r_out_vld_q || out_rdy;
    assign req_rdy      = (r_state_q == ST_IDLE) && w_slot_free;
    assign w_accept     = req_vld && req_rdy;
    assign w_li_two     = (req_op == OP_LI) && !f_fits_signed(req_imm, 12);
    assign w_load_first = w_accept && w_enc_legal;
    assign w_load_addi  = (r_state_q == ST_LI2) && w_slot_free;
    assign w_out_pc_d   = r_out_pc_q + 32'd4;

    // Second LI word: ADDI rd,rd,lo where lo is the sign-extended low 12 bits.
    assign w_addi_inst  = f_enc_i(r_li_lo_q, r_li_rd_q, F3_ADD_SUB, r_li_rd_q, OPC_OP_IMM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_out_vld_q  <= 1'b0;
            r_out_inst_q <= '0;
            r_out_pc_q   <= BASE_PC;
            r_err_q      <= 1'b0;
            r_li_rd_q    <= '0;
            r_li_lo_q    <= '0;
        end else begin
            // The pc tracks the slot: it advances only when a word leaves.
            if (w_drain) begin
                r_out_pc_q <= w_out_pc_d;
            end

            if (w_load_first) begin
                r_out_vld_q  <= 1'b1;
                r_out_inst_q <= w_enc_inst;
            end else if (w_load_addi) begin
                r_out_vld_q  <= 1'b1;
                r_out_inst_q <= w_addi_inst;
            end else if (w_drain) begin
                r_out_vld_q  <= 1'b0;
            end

            if (w_accept && !w_enc_legal) begin
                r_err_q <= 1'b1;
            end

            case (r_state_q)
                ST_IDLE: begin
                    if (w_accept && w_li_two) begin
                        r_state_q <= ST_LI2;
                        r_li_rd_q <= req_rd;
                        r_li_lo_q <= req_imm[11:0];
                    end
                end
                ST_LI2: begin
                    if (w_load_addi) begin
                        r_state_q <= ST_IDLE;
                    end
                end
                default: r_state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_vld  = r_out_vld_q;
    assign out_inst = r_out_inst_q;
    assign out_pc   = r_out_pc_q;
    assign err      = r_err_q;

endmodule : inst_encoder
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder. Directed literal
//               sequences followed by randomized traffic compared against a
//               queue-based reference model of the emitted instruction stream.
// Config      : ENC_MEXT_EN - selects M-extension expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;   // wraps after four words
`ifdef ENC_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [3:0]  req_op;
    logic [4:0]  req_func;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        err;

    inst_encoder #(.BASE_PC(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_op   (req_op),
        .req_func (req_func),
        .req_rd   (req_rd),
        .req_rs1  (req_rs1),
        .req_rs2  (req_rs2),
        .req_imm  (req_imm),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic bit fits(input logic [31:0] v, input int bits);
        longint s;
        longint lim;
        s   = longint'(signed'(v));
        lim = longint'(1) << (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    // Reference encoder: what the instruction stream must contain for one
    // request, built from the RV32 field layout with plain arithmetic.
    function automatic void model_enc(input int op, input int func, input int rd, input int rs1,
                                      input int rs2, input logic [31:0] imm,
                                      output bit legal, output int nw,
                                      output logic [31:0] w0, output logic [31:0] w1);
        int f3tab [18] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
        logic [31:0] d, a, b, f3, f7;
        d = 32'(rd); a = 32'(rs1); b = 32'(rs2); f3 = 32'(func % 8);
        legal = 1'b0; nw = 0; w0 = '0; w1 = '0;
        case (op)
            0: if (func < 10 || (MEXT && func < 18)) begin
                f7 = (func >= 10) ? 32'd1 : ((func == 1 || func == 7) ? 32'd32 : 32'd0);
                w0 = (f7 << 25) | (b << 20) | (a << 15) | (32'(f3tab[func]) << 12) | (d << 7) | 32'h33;
                legal = 1'b1;
            end
            1: if (func < 10 && func != 1) begin
                if (func == 2 || func == 6 || func == 7) begin
                    w0 = ((func == 7) ? 32'h4000_0000 : 32'h0) | ((imm & 32'h1F) << 20);
                    legal = 1'b1;
                end else begin
                    w0 = (imm & 32'hFFF) << 20;
                    legal = fits(imm, 12);
                end
                w0 = w0 | (a << 15) | (32'(f3tab[func]) << 12) | (d << 7) | 32'h13;
            end
            2: begin legal = fits(imm, 12); w0 = ((imm & 32'hFFF) << 20) | (a << 15) | (f3 << 12) | (d << 7) | 32'h03; end
            3: begin
                legal = fits(imm, 12);
                w0 = (((imm >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f3 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4: begin
                legal = fits(imm, 13) && (imm % 2 == 0);
                w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (b << 20) | (a << 15)
                   | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                legal = fits(imm, 21) && (imm % 2 == 0);
                w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
            end
            6: begin legal = fits(imm, 12); w0 = ((imm & 32'hFFF) << 20) | (a << 15) | (d << 7) | 32'h67; end
            7: begin legal = 1'b1; w0 = (imm & 32'hFFFF_F000) | (d << 7) | 32'h37; end
            8: begin legal = 1'b1; w0 = (imm & 32'hFFFF_F000) | (d << 7) | 32'h17; end
            9: begin legal = 1'b1; w0 = 32'h0010_0073; end
            10: begin
                legal = 1'b1;
                if (fits(imm, 12)) begin
                    w0 = ((imm & 32'hFFF) << 20) | (d << 7) | 32'h13;
                end else begin
                    w0 = ((imm + 32'h800) & 32'hFFFF_F000) | (d << 7) | 32'h37;
                    w1 = ((imm & 32'hFFF) << 20) | (d << 15) | (d << 7) | 32'h13;
                end
            end
            default: legal = 1'b0;
        endcase
        if (legal) nw = (op == 10 && !fits(imm, 12)) ? 2 : 1;
    endfunction

    task automatic set_req(input int op, input int func, input int rd, input int rs1,
                           input int rs2, input logic [31:0] imm);
        req_op = 4'(op); req_func = 5'(func); req_rd = 5'(rd);
        req_rs1 = 5'(rs1); req_rs2 = 5'(rs2); req_imm = imm;
    endtask

    logic [31:0] q[$];
    logic [31:0] mpc;
    bit          merr;
    bit          mlegal;
    int          mnw;
    logic [31:0] m0, m1, p;
    bit          exp_rdy;
    int          bl [14] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                             1048574, 1048575, 1048576, -1048576, -1048578};

    initial begin
        rst = 1'b1; req_vld = 1'b0; out_rdy = 1'b0;
        set_req(0, 0, 0, 0, 0, 32'h0);

        // Pin the reference model to hand-computed encodings.
        model_enc(0, 0, 3, 1, 2, 32'h0, mlegal, mnw, m0, m1);
        chk("model_add", m0, 32'h0020_81B3);
        model_enc(10, 0, 5, 0, 0, 32'h1234_5678, mlegal, mnw, m0, m1);
        chk("model_li_lui", m0, 32'h1234_52B7);
        chk("model_li_addi", m1, 32'h6782_8293);
        model_enc(10, 0, 1, 0, 0, 32'hFFFF_FFFF, mlegal, mnw, m0, m1);
        chk("model_li_m1_words", 32'(mnw), 32'd1);
        model_enc(4, 0, 0, 1, 2, 32'd4097, mlegal, mnw, m0, m1);
        chk("model_br_odd_legal", 32'(mlegal), 32'd0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, BASE);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // ADD, then LI big with no bubble between them.
        @(negedge clk); out_rdy = 1'b1; set_req(OP_R, ALU_ADD, 3, 1, 2, 0); req_vld = 1'b1;
        #1 chk("add_req_rdy", req_rdy, 1);
        @(negedge clk); req_vld = 1'b0; #1;
        chk("add_vld", out_vld, 1);
        chk("add_inst", out_inst, 32'h0020_81B3);
        chk("add_pc", out_pc, BASE);
        set_req(OP_LI, 0, 5, 0, 0, 32'h1234_5678); req_vld = 1'b1;
        #1 chk("nobubble_req_rdy", req_rdy, 1);
        @(negedge clk); req_vld = 1'b0; #1;
        chk("li_lui", out_inst, 32'h1234_52B7);
        chk("li_lui_pc", out_pc, BASE + 32'd4);
        chk("li2_req_rdy", req_rdy, 0);
        @(negedge clk); #1;
        chk("li_addi", out_inst, 32'h6782_8293);
        chk("li_addi_pc", out_pc, BASE + 32'd8);
        chk("li_addi_vld", out_vld, 1);
        set_req(OP_LI, 0, 1, 0, 0, 32'h0000_0800); req_vld = 1'b1;
        @(negedge clk); req_vld = 1'b0; #1;
        chk("li800_lui", out_inst, 32'h0000_10B7);
        chk("li800_lui_pc", out_pc, BASE + 32'd12);
        @(negedge clk); #1;
        chk("li800_addi", out_inst, 32'h8000_8093);
        chk("pc_wrap", out_pc, 32'h0);
        set_req(OP_LI, 0, 1, 0, 0, 32'hFFFF_FFFF); req_vld = 1'b1;
        @(negedge clk); req_vld = 1'b0; #1;
        chk("li_m1", out_inst, 32'hFFF0_0093);
        chk("li_m1_pc", out_pc, BASE + 32'd20);
        set_req(OP_R, ALU_MUL, 3, 1, 2, 0); req_vld = 1'b1;
        @(negedge clk); req_vld = 1'b0; #1;
        if (MEXT) begin
            chk("mul_inst", out_inst, 32'h0220_81B3);
            chk("mul_pc", out_pc, BASE + 32'd24);
            p = BASE + 32'd28;
        end else begin
            chk("mul_illegal_vld", out_vld, 0);
            chk("mul_illegal_err", err, 1);
            chk("mul_illegal_pc", out_pc, BASE + 32'd24);
            p = BASE + 32'd24;
        end

        // Back-pressure: slot must hold steady for three stalled cycles.
        @(negedge clk); out_rdy = 1'b0; set_req(OP_R, ALU_ADD, 3, 1, 2, 0); req_vld = 1'b1;
        #1 chk("stall_req_rdy_empty", req_rdy, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req_vld = 1'b0; #1;
            chk("stall_vld", out_vld, 1);
            chk("stall_inst", out_inst, 32'h0020_81B3);
            chk("stall_pc", out_pc, p);
            chk("stall_req_rdy", req_rdy, 0);
        end
        chk("err_sticky", err, MEXT ? 0 : 1);

        // Reset during LI2 drops the pending ADDI.
        @(negedge clk); out_rdy = 1'b1; set_req(OP_LI, 0, 5, 0, 0, 32'h1234_5678); req_vld = 1'b1;
        #1 chk("pre_li_req_rdy", req_rdy, 1);
        @(negedge clk); req_vld = 1'b0; #1;
        chk("li2_lui_before_rst", out_inst, 32'h1234_52B7);
        chk("li2_pc_before_rst", out_pc, p + 32'd4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("li2_rst_vld", out_vld, 0);
        chk("li2_rst_pc", out_pc, BASE);
        chk("li2_rst_err", err, 0);
        chk("li2_rst_req_rdy", req_rdy, 1);
        @(negedge clk); #1;
        chk("li2_rst_no_addi", out_vld, 0);

        // Randomized traffic against the stream model.
        q.delete(); mpc = BASE; merr = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) == 0);
            out_rdy = ($urandom_range(0, 99) < 70);
            req_vld = ($urandom_range(0, 99) < 60);
            req_op   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
            req_func = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
            req_rd   = 5'($urandom_range(0, 31));
            req_rs1  = 5'($urandom_range(0, 31));
            req_rs2  = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: req_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                1: req_imm = $urandom;
                2: req_imm = 32'(bl[$urandom_range(0, 13)]);
                3: req_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
                default: req_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            endcase
            #1;
            exp_rdy = (q.size() < 2) && (q.size() == 0 || out_rdy);
            chk("rnd_out_vld", out_vld, 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_out_inst", out_inst, q[0]);
                chk("rnd_out_pc", out_pc, mpc);
            end
            chk("rnd_err", err, 32'(merr));
            chk("rnd_req_rdy", req_rdy, 32'(exp_rdy));
            if (rst) begin
                q.delete(); mpc = BASE; merr = 1'b0;
            end else begin
                if (q.size() > 0 && out_rdy) begin
                    void'(q.pop_front());
                    mpc = mpc + 32'd4;
                end
                if (req_vld && exp_rdy) begin
                    model_enc(int'(req_op), int'(req_func), int'(req_rd), int'(req_rs1),
                              int'(req_rs2), req_imm, mlegal, mnw, m0, m1);
                    if (mlegal) begin
                        q.push_back(m0);
                        if (mnw == 2) q.push_back(m1);
                    end else begin
                        merr = 1'b1;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_inst_encoder
`default_nettype wire
